nand_bundle_fault_campaign: RTL and testbench

Synthesizable self-checking campaign engine for the multiplexed NAND circuit under test. It generates pseudo-random logical operands and drives each one as an N-wire bundle (all-ones or all-zeros). It waits for the circuit's valid, majority-decodes the output bundle and compares it against a golden function. It accumulates logical-error, wire-error and timeout statistics over a programmable number of trials, so error-probability sweeps run unattended in simulation or on FPGA.

---
 rtl/nand_bundle_fault_campaign.sv | 220 ++++++++++++++++++++++
 tb/tb_nand_bundle_fault_campaign.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_bundle_fault_campaign.sv
// -----------------------------------------------------------------------------
// nand_bundle_fault_campaign
//
// Self-checking campaign engine for a multiplexed (bundled) logic circuit.
// Each trial draws two logical operand bits from a 16-bit Galois LFSR and
// drives each one as an N-wire bundle (all ones or all zeros). The engine
// waits for the circuit's valid, majority-decodes the returned bundle and
// compares it with the golden function of the operands. Logical errors,
// individual wire errors and timeouts are accumulated over NUM_TRIALS trials.
//
// Ports
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-high reset
//   start_i        in   one-cycle pulse, starts a campaign when idle or done
//   x_o, y_o       out  [N]     operand bundles to the circuit
//   z_i            in   [N]     output bundle from the circuit
//   valid_i        in   circuit result valid
//   busy_o         out  campaign in progress
//   done_o         out  campaign finished (sticky until next start)
//   trials_o       out  [CNT_W] completed trials, timeouts included
//   logical_err_o  out  [CNT_W] trials whose decoded z differed from golden
//   wire_err_o     out  [CNT_W] total wires of z that differed from golden
//   timeout_o      out  [CNT_W] abandoned trials
// -----------------------------------------------------------------------------
module nand_bundle_fault_campaign #(
  parameter int          N          = 10,
  parameter int          NUM_TRIALS = 1000,
  parameter int          CNT_W      = 32,
  parameter int          THRESHOLD  = N / 2 + 1,
  parameter int          GUARD      = 2,
  parameter int          TIMEOUT    = 64,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  output logic [N-1:0]     x_o,
  output logic [N-1:0]     y_o,
  input  logic [N-1:0]     z_i,
  input  logic             valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] trials_o,
  output logic [CNT_W-1:0] logical_err_o,
  output logic [CNT_W-1:0] wire_err_o,
  output logic [CNT_W-1:0] timeout_o
);

  localparam int PC_W = $clog2(N + 1);
  localparam int TR_W = $clog2(NUM_TRIALS + 1);
  localparam int WT_W = $clog2(TIMEOUT);

  localparam logic [15:0]      SEED_EFF     = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0]      LFSR_MASK    = 16'hB400;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  // The LOAD cycle is the first guard cycle, so valid is accepted once
  // GUARD-1 WAIT cycles have elapsed: a trial then takes GUARD+2 cycles.
  localparam logic [WT_W-1:0]  GUARD_LAST   = WT_W'(GUARD - 1);
  localparam logic [WT_W-1:0]  TIMEOUT_LAST = WT_W'(TIMEOUT - 1);
  localparam logic [TR_W-1:0]  TRIAL_LAST   = TR_W'(NUM_TRIALS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  function automatic logic [PC_W-1:0] popcount(input logic [N-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [PC_W-1:0]  a);
    logic [CNT_W:0] sum;
    sum = {1'b0, c} + (CNT_W + 1)'(a);
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  function automatic logic golden_fn(input logic a, input logic b);
    case (MODE)
      0:       return ~(a & b);
      1:       return a & b;
      2:       return a ^ b;
      default: return a | b;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_next;
  logic [N-1:0]     r_x;
  logic [N-1:0]     r_y;
  logic [N-1:0]     r_z;
  logic             r_golden;
  logic [WT_W-1:0]  r_wait_cnt;
  logic [TR_W-1:0]  r_trial_cnt;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_trials;
  logic [CNT_W-1:0] r_logical_err;
  logic [CNT_W-1:0] r_wire_err;
  logic [CNT_W-1:0] r_timeout;

  logic             w_accept;
  logic             w_timeout;
  logic             w_last_trial;
  logic [PC_W-1:0]  w_wire_diff;
  logic             w_decoded;

  assign w_lfsr_next  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
  // Acceptance outranks a timeout landing on the same cycle.
  assign w_accept     = (r_state == S_WAIT) && valid_i && (r_wait_cnt >= GUARD_LAST);
  assign w_timeout    = (r_state == S_WAIT) && !w_accept && (r_wait_cnt == TIMEOUT_LAST);
  // Termination uses its own counter so saturated statistics cannot stall it.
  assign w_last_trial = (r_trial_cnt == TRIAL_LAST);
  assign w_wire_diff  = popcount(r_z ^ {N{r_golden}});
  // A threshold above N can never be met, so decoded stays 0 in that case.
  assign w_decoded    = int'(popcount(r_z)) >= THRESHOLD;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start_i) w_state_next = S_LOAD;
      S_LOAD:         w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_accept)       w_state_next = S_CHECK;
        else if (w_timeout) w_state_next = w_last_trial ? S_DONE : S_LOAD;
      end
      S_CHECK:        w_state_next = w_last_trial ? S_DONE : S_LOAD;
      default:        w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_lfsr        <= SEED_EFF;
      r_x           <= '0;
      r_y           <= '0;
      r_z           <= '0;
      r_golden      <= 1'b0;
      r_wait_cnt    <= '0;
      r_trial_cnt   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_trials      <= '0;
      r_logical_err <= '0;
      r_wire_err    <= '0;
      r_timeout     <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_LOAD) || (w_state_next == S_WAIT) ||
                 (w_state_next == S_CHECK);
      r_done  <= (w_state_next == S_DONE);

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_lfsr        <= SEED_EFF;
            r_trial_cnt   <= '0;
            r_trials      <= '0;
            r_logical_err <= '0;
            r_wire_err    <= '0;
            r_timeout     <= '0;
          end
        end
        S_LOAD: begin
          r_lfsr     <= w_lfsr_next;
          r_x        <= {N{w_lfsr_next[0]}};
          r_y        <= {N{w_lfsr_next[1]}};
          r_golden   <= golden_fn(w_lfsr_next[0], w_lfsr_next[1]);
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          if (w_accept) begin
            r_z <= z_i;
          end else if (w_timeout) begin
            r_timeout   <= sat_inc(r_timeout);
            r_trials    <= sat_inc(r_trials);
            r_trial_cnt <= r_trial_cnt + 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_wire_err  <= sat_add(r_wire_err, w_wire_diff);
          r_trials    <= sat_inc(r_trials);
          r_trial_cnt <= r_trial_cnt + 1'b1;
          if (w_decoded != r_golden) r_logical_err <= sat_inc(r_logical_err);
        end
        default: ;
      endcase
    end
  end

  assign x_o           = r_x;
  assign y_o           = r_y;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign trials_o      = r_trials;
  assign logical_err_o = r_logical_err;
  assign wire_err_o    = r_wire_err;
  assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_nand_bundle_fault_campaign.sv
// -----------------------------------------------------------------------------
// tb_nand_bundle_fault_campaign
//
// Three campaign engines share clock and reset:
//   main  N=10, 1000 trials, NAND  - operand sequence, wire/logical errors,
//                                    guard window, random valid, mid-run reset
//   small N=10, 5 trials,    OR    - timeout campaign and OR golden function
//   sat   N=10, 20 trials, AND, CNT_W=4 - counter saturation
// The circuit under test is modelled by the bench: it returns the golden
// bundle computed from the observed operands, optionally with wires flipped.
// -----------------------------------------------------------------------------
module tb_nand_bundle_fault_campaign;

  localparam int          N      = 10;
  localparam int          M_TH   = N / 2 + 1;
  localparam int          M_TRI  = 1000;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- main instance ----------------
  logic          m_start = 1'b0, m_valid = 1'b0, m_corrupt = 1'b0;
  logic [N-1:0]  m_mask = '0;
  logic [N-1:0]  m_x, m_y, m_z;
  logic          m_busy, m_done;
  logic [31:0]   m_trials, m_lerr, m_werr, m_tout;

  // ---------------- small instance ----------------
  logic          s_start = 1'b0, s_valid = 1'b0;
  logic [N-1:0]  s_x, s_y, s_z;
  logic          s_busy, s_done;
  logic [31:0]   s_trials, s_lerr, s_werr, s_tout;

  // ---------------- saturation instance ----------------
  logic          t_start = 1'b0, t_valid = 1'b0;
  logic [N-1:0]  t_x, t_y, t_z;
  logic          t_busy, t_done;
  logic [3:0]    t_trials, t_lerr, t_werr, t_tout;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Truth tables by operand sum: 0 = NAND, 1 = AND, 2 = XOR, 3 = OR.
  function automatic logic gold_model(input int mode, input logic a, input logic b);
    int s;
    s = int'(a) + int'(b);
    case (mode)
      0:       return s != 2;
      1:       return s == 2;
      2:       return s == 1;
      default: return s >= 1;
    endcase
  endfunction

  function automatic logic [N-1:0] rand_mask_k(input int k);
    logic [N-1:0] m;
    m = '0;
    while ($countones(m) < k) m[$urandom_range(0, N - 1)] = 1'b1;
    return m;
  endfunction

  always_comb m_z = {N{gold_model(0, m_x[0], m_y[0])}} ^ m_mask ^ {N{m_corrupt}};
  always_comb s_z = {N{gold_model(3, s_x[0], s_y[0])}};
  always_comb t_z = ~{N{gold_model(1, t_x[0], t_y[0])}};

  nand_bundle_fault_campaign #(.N(N), .NUM_TRIALS(M_TRI), .CNT_W(32), .GUARD(2),
    .TIMEOUT(64), .SEED(SEED), .MODE(0)) u_main (
    .clk(clk), .reset(reset), .start_i(m_start), .x_o(m_x), .y_o(m_y), .z_i(m_z),
    .valid_i(m_valid), .busy_o(m_busy), .done_o(m_done), .trials_o(m_trials),
    .logical_err_o(m_lerr), .wire_err_o(m_werr), .timeout_o(m_tout));

  nand_bundle_fault_campaign #(.N(N), .NUM_TRIALS(5), .CNT_W(32), .GUARD(2),
    .TIMEOUT(64), .SEED(SEED), .MODE(3)) u_small (
    .clk(clk), .reset(reset), .start_i(s_start), .x_o(s_x), .y_o(s_y), .z_i(s_z),
    .valid_i(s_valid), .busy_o(s_busy), .done_o(s_done), .trials_o(s_trials),
    .logical_err_o(s_lerr), .wire_err_o(s_werr), .timeout_o(s_tout));

  nand_bundle_fault_campaign #(.N(N), .NUM_TRIALS(20), .CNT_W(4), .GUARD(2),
    .TIMEOUT(64), .SEED(SEED), .MODE(1)) u_sat (
    .clk(clk), .reset(reset), .start_i(t_start), .x_o(t_x), .y_o(t_y), .z_i(t_z),
    .valid_i(t_valid), .busy_o(t_busy), .done_o(t_done), .trials_o(t_trials),
    .logical_err_o(t_lerr), .wire_err_o(t_werr), .timeout_o(t_tout));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic pulse_main();
    m_start = 1'b1;
    tick(1);
    m_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({m_x, m_y, m_busy, m_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: x=%h y=%h busy=%b done=%b, required all 0", m_x, m_y, m_busy, m_done);
    end
    n_checks++;
    if ({m_trials, m_lerr, m_werr, m_tout} !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: %0d/%0d/%0d/%0d, required 0", m_trials, m_lerr, m_werr, m_tout);
    end
    n_checks++;
    if ({s_busy, s_done, t_busy, t_done, t_trials} !== '0) begin
      n_fail++;
      $display("FAIL reset_others: got nonzero, required 0");
    end
  endtask

  // Valid held high: trial t has LOAD at edge 4t+1 after the start edge,
  // WAIT at 4t+2..4t+3 and CHECK at 4t+4. The bundle is inverted during the
  // first WAIT cycle, so any sample taken inside the guard window shows up.
  task automatic run_sched(input string name, input bit rand_mask,
                           input int k, input bit poke_start);
    logic [15:0]  l;
    logic [N-1:0] mask;
    logic         xb, yb, g;
    int           exp_w, exp_l, seq_bad, pc;
    l = SEED; exp_w = 0; exp_l = 0; seq_bad = 0;
    m_valid = 1'b1; m_corrupt = 1'b0;
    mask = rand_mask ? '0 : rand_mask_k(k);
    pulse_main();
    n_checks++;
    if (m_busy !== 1'b1 || m_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_after_start: busy=%b done=%b, required 1/0", name, m_busy, m_done);
    end
    for (int t = 0; t < M_TRI; t++) begin
      tick(1);
      l  = lfsr_step(l);
      xb = l[0]; yb = l[1];
      if (m_x !== {N{xb}} || m_y !== {N{yb}}) seq_bad++;
      if (rand_mask) mask = N'($urandom_range(0, (1 << N) - 1));
      m_mask = mask; m_corrupt = 1'b1;
      m_start = poke_start && (t == 10);
      g  = gold_model(0, xb, yb);
      pc = g ? N - $countones(mask) : $countones(mask);
      exp_w += $countones(mask);
      if ((pc >= M_TH) != g) exp_l++;
      tick(1);
      m_corrupt = 1'b0; m_start = 1'b0;
      tick(1);
      if (t == M_TRI - 1) begin
        n_checks++;
        if (m_done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_early_done: done=%b one cycle before end, required 0", name, m_done);
        end
      end
      tick(1);
    end
    n_checks++;
    if (seq_bad != 0) begin
      n_fail++;
      $display("FAIL %s_operand_seq: %0d trials with wrong x/y, required 0", name, seq_bad);
    end
    n_checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: done=%b busy=%b, required 1/0", name, m_done, m_busy);
    end
    n_checks++;
    if (m_trials !== 32'(M_TRI) || m_tout !== 32'd0) begin
      n_fail++;
      $display("FAIL %s_trials: trials=%0d timeouts=%0d, required %0d/0", name, m_trials, m_tout, M_TRI);
    end
    n_checks++;
    if (m_lerr !== 32'(exp_l)) begin
      n_fail++;
      $display("FAIL %s_logical_err: got %0d, required %0d", name, m_lerr, exp_l);
    end
    n_checks++;
    if (m_werr !== 32'(exp_w)) begin
      n_fail++;
      $display("FAIL %s_wire_err: got %0d, required %0d", name, m_werr, exp_w);
    end
    m_mask = '0;
  endtask

  task automatic test_ideal();
    run_sched("ideal", 1'b0, 0, 1'b1);
  endtask

  task automatic test_wire_flips();
    run_sched("flip3", 1'b0, 3, 1'b0);
    run_sched("flip5", 1'b0, 5, 1'b0);
  endtask

  task automatic test_random_flips();
    run_sched("randflip", 1'b1, 0, 1'b0);
  endtask

  task automatic test_random_valid();
    logic [15:0]  l;
    logic         g;
    int           k, exp_l, cycles, pc;
    k = $urandom_range(0, N);
    m_mask = rand_mask_k(k); m_corrupt = 1'b0; m_valid = 1'b0;
    l = SEED; exp_l = 0;
    for (int t = 0; t < M_TRI; t++) begin
      l  = lfsr_step(l);
      g  = gold_model(0, l[0], l[1]);
      pc = g ? N - k : k;
      if ((pc >= M_TH) != g) exp_l++;
    end
    pulse_main();
    cycles = 0;
    while (!m_done && cycles < 30000) begin
      m_valid = ($urandom_range(0, 2) == 0);
      tick(1);
      cycles++;
    end
    n_checks++;
    if (m_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rv_done: done=%b after %0d cycles, required 1", m_done, cycles);
    end
    n_checks++;
    if (m_trials !== 32'(M_TRI) || m_tout !== 32'd0) begin
      n_fail++;
      $display("FAIL rv_trials: trials=%0d timeouts=%0d, required %0d/0", m_trials, m_tout, M_TRI);
    end
    n_checks++;
    if (m_lerr !== 32'(exp_l) || m_werr !== 32'(k * M_TRI)) begin
      n_fail++;
      $display("FAIL rv_errors: logical=%0d wire=%0d, required %0d/%0d", m_lerr, m_werr, exp_l, k * M_TRI);
    end
    m_mask = '0; m_valid = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] l;
    l = lfsr_step(SEED);
    m_valid = 1'b1; m_mask = '0; m_corrupt = 1'b0;
    pulse_main();
    tick(1 + 4 * 37);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_checks++;
    if ({m_x, m_y, m_busy, m_done, m_trials, m_lerr, m_werr, m_tout} !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: x=%h y=%h busy=%b done=%b trials=%0d, required all 0",
               m_x, m_y, m_busy, m_done, m_trials);
    end
    tick(1);
    n_checks++;
    if (m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: busy=%b, required 0", m_busy);
    end
    pulse_main();
    tick(1);
    n_checks++;
    if (m_x !== {N{l[0]}} || m_y !== {N{l[1]}}) begin
      n_fail++;
      $display("FAIL midreset_first_operand: x=%h y=%h, required %h/%h", m_x, m_y, {N{l[0]}}, {N{l[1]}});
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int cycles;
    s_valid = 1'b0;
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    cycles = 0;
    while (!s_done && cycles < 1000) begin
      tick(1);
      cycles++;
    end
    n_checks++;
    if (cycles != 5 * 65) begin
      n_fail++;
      $display("FAIL timeout_latency: done after %0d cycles, required %0d", cycles, 5 * 65);
    end
    n_checks++;
    if (s_tout !== 32'd5 || s_trials !== 32'd5) begin
      n_fail++;
      $display("FAIL timeout_counts: timeouts=%0d trials=%0d, required 5/5", s_tout, s_trials);
    end
    n_checks++;
    if (s_lerr !== 32'd0 || s_werr !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout_errors: logical=%0d wire=%0d, required 0/0", s_lerr, s_werr);
    end
  endtask

  task automatic test_or_mode();
    int cycles;
    s_valid = 1'b1;
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    cycles = 0;
    while (!s_done && cycles < 1000) begin
      tick(1);
      cycles++;
    end
    n_checks++;
    if (cycles != 5 * 4) begin
      n_fail++;
      $display("FAIL or_latency: done after %0d cycles, required 20", cycles);
    end
    n_checks++;
    if (s_trials !== 32'd5 || s_tout !== 32'd0 || s_lerr !== 32'd0 || s_werr !== 32'd0) begin
      n_fail++;
      $display("FAIL or_counts: trials=%0d to=%0d logical=%0d wire=%0d, required 5/0/0/0",
               s_trials, s_tout, s_lerr, s_werr);
    end
  endtask

  task automatic test_saturation();
    int cycles;
    t_valid = 1'b1;
    t_start = 1'b1;
    tick(1);
    t_start = 1'b0;
    cycles = 0;
    while (!t_done && cycles < 1000) begin
      tick(1);
      cycles++;
    end
    n_checks++;
    if (cycles != 20 * 4) begin
      n_fail++;
      $display("FAIL sat_latency: done after %0d cycles, required 80", cycles);
    end
    n_checks++;
    if (t_trials !== 4'd15 || t_lerr !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_counts: trials=%0d logical=%0d, required 15/15", t_trials, t_lerr);
    end
    n_checks++;
    if (t_werr !== 4'd15 || t_tout !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_wire: wire=%0d timeouts=%0d, required 15/0", t_werr, t_tout);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_wire_flips();
    test_random_flips();
    test_random_valid();
    test_reset_mid();
    test_timeout();
    test_or_mode();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
